// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits sharing one decoder.
// Double-buffered digit codes; active-low digit enables with a blanking gap before every lit period.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [2:0]              bcd,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    upd_ack
);

    localparam int MAXC  = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int SEL_W = $clog2(NUM_DIGITS);
    localparam int DW    = 3 * NUM_DIGITS;

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [SEL_W-1:0]      r_sel;
    logic [DW-1:0]         r_shadow;
    logic [NUM_DIGITS-1:0] r_shen;
    logic [DW-1:0]         r_pend;
    logic [NUM_DIGITS-1:0] r_pend_en;
    logic                  r_pend_valid;
    logic [2:0]            r_bcd;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_fd;
    logic                  r_ack;

    state_t                w_nstate;
    logic [CNT_W-1:0]      w_ncnt;
    logic [SEL_W-1:0]      w_nsel;
    logic                  w_xfer;
    logic [DW-1:0]         w_nshadow;
    logic [NUM_DIGITS-1:0] w_nshen;
    logic                  w_npend_valid;
    logic [2:0]            w_ncode;
    logic [NUM_DIGITS-1:0] w_nan;
    logic                  w_nfd;
    logic                  w_nack;

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt + 1'b1;
        w_nsel   = r_sel;
        case (r_state)
            BLANK: begin
                if (r_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    w_nstate = SHOW;
                    w_ncnt   = '0;
                end
            end
            SHOW: begin
                if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                    w_nstate = BLANK;
                    w_ncnt   = '0;
                    w_nsel   = (r_sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : r_sel + 1'b1;
                end
            end
            default: begin
                w_nstate = BLANK;
                w_ncnt   = '0;
            end
        endcase

        w_xfer        = (r_state == BLANK) && (r_sel == '0) && (r_cnt == '0) && r_pend_valid;
        w_nshadow     = w_xfer ? r_pend : r_shadow;
        w_nshen       = w_xfer ? r_pend_en : r_shen;
        w_npend_valid = load | (r_pend_valid & ~w_xfer);

        w_ncode = w_nshadow[w_nsel*3 +: 3];
        w_nan   = '1;
        if ((w_nstate == SHOW) && w_nshen[w_nsel] && (w_ncode != 3'd7))
            w_nan[w_nsel] = 1'b0;

        w_nfd  = (w_nstate == SHOW) && (w_nsel == SEL_W'(NUM_DIGITS - 1)) &&
                 (w_ncnt == CNT_W'(REFRESH_DIV - 1));
        w_nack = (w_nstate == BLANK) && (w_nsel == '0) && (w_ncnt == '0) && w_npend_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= BLANK;
            r_cnt        <= '0;
            r_sel        <= '0;
            r_shadow     <= '1;
            r_shen       <= '0;
            r_pend       <= '1;
            r_pend_en    <= '0;
            r_pend_valid <= 1'b0;
            r_bcd        <= '0;
            r_an         <= '1;
            r_fd         <= 1'b0;
            r_ack        <= 1'b0;
        end else begin
            r_state      <= w_nstate;
            r_cnt        <= w_ncnt;
            r_sel        <= w_nsel;
            r_shadow     <= w_nshadow;
            r_shen       <= w_nshen;
            r_pend_valid <= w_npend_valid;
            if (load) begin
                r_pend    <= digits;
                r_pend_en <= digit_en;
            end
            r_bcd <= w_ncode;
            r_an  <= w_nan;
            r_fd  <= w_nfd;
            r_ack <= w_nack;
        end
    end

    assign bcd        = r_bcd;
    assign an         = r_an;
    assign frame_done = r_fd;
    assign upd_ack    = r_ack;

endmodule
